// File: rtl/multiword_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : multiword_add_seq
// Brief    : Multi-precision add/subtract sequencer. Computes an N*W-bit
//            sum or difference through one shared W-bit adder, one word per
//            cycle, least-significant word first, with a carry register
//            linking consecutive words.
// Revision : 1.0 - initial release
// ============================================================================
module multiword_add_seq #(
  parameter int W  = 32,
  parameter int N  = 4,
  parameter int CW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           sub,
  input  logic           cin,
  input  logic [N*W-1:0] A,
  input  logic [N*W-1:0] B,
  output logic           busy,
  output logic           done,
  output logic [N*W-1:0] S,
  output logic           cout,
  output logic           ovf
);

  localparam logic [1:0]    c_ST_IDLE = 2'd0;
  localparam logic [1:0]    c_ST_RUN  = 2'd1;
  localparam logic [1:0]    c_ST_DONE = 2'd2;
  localparam logic [CW-1:0] c_LAST    = CW'(N - 1);

  logic [1:0]     r_state;
  logic [N*W-1:0] r_a;
  logic [N*W-1:0] r_b;
  logic [N*W-1:0] r_s;
  logic           r_carry;
  logic [CW-1:0]  r_idx;
  logic           r_cout;
  logic           r_ovf;

  logic [W:0]     w_sum;
  logic           w_last;

  // Shared W-bit adder: low word of each operand shift register plus carry.
  always_comb begin
    w_sum  = {1'b0, r_a[W-1:0]} + {1'b0, r_b[W-1:0]} + {{W{1'b0}}, r_carry};
    w_last = (r_idx == c_LAST);
  end

  // Sequencer: capture, word-serial add with right-shifting result, done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1, so invert B once at capture.
            r_a     <= A;
            r_b     <= sub ? ~B : B;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
            r_state <= c_ST_RUN;
          end
        end
        c_ST_RUN: begin
          r_s     <= {w_sum[W-1:0], r_s[N*W-1:W]};
          r_a     <= r_a >> W;
          r_b     <= r_b >> W;
          r_carry <= w_sum[W];
          r_idx   <= r_idx + CW'(1);
          if (w_last) begin
            // Top word: operand MSBs here are the sign bits of the full values.
            r_cout  <= w_sum[W];
            r_ovf   <= (r_a[W-1] == r_b[W-1]) && (w_sum[W-1] != r_a[W-1]);
            r_state <= c_ST_DONE;
          end
        end
        c_ST_DONE: begin
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state == c_ST_RUN);
  assign done = (r_state == c_ST_DONE);
  assign S    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_multiword_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiword_add_seq
// Brief    : Self-checking bench for multiword_add_seq (W=8, N=4). Expected
//            results come from a full-width reference model, queued at start
//            and compared whenever the DUT pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiword_add_seq;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int NW = N * W;

  typedef struct packed {
    logic [NW-1:0] s;
    logic          c;
    logic          o;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic          sub;
  logic          cin;
  logic [NW-1:0] A;
  logic [NW-1:0] B;
  logic          busy;
  logic          done;
  logic [NW-1:0] S;
  logic          cout;
  logic          ovf;

  int   errors;
  int   checks;
  int   n_done;
  exp_t sb[$];

  multiword_add_seq #(.W(W), .N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sub  (sub),
    .cin  (cin),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .S    (S),
    .cout (cout),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-width arithmetic, independent of the word-serial datapath.
  function automatic exp_t model(input logic [NW-1:0] a, input logic [NW-1:0] b,
                                 input logic s, input logic c);
    logic [NW:0]   f;
    logic [NW-1:0] be;
    logic          ci;
    exp_t          e;
    be  = s ? ~b : b;
    ci  = s ? 1'b1 : c;
    f   = {1'b0, a} + {1'b0, be} + {{NW{1'b0}}, ci};
    e.s = f[NW-1:0];
    e.c = f[NW];
    e.o = (a[NW-1] == be[NW-1]) && (f[NW-1] != a[NW-1]);
    return e;
  endfunction

  // Scoreboard consumer: every done pulse pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      n_done++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1 S=%h, required no done (queue empty)", S);
      end else begin
        e = sb.pop_front();
        if ({S, cout, ovf} !== {e.s, e.c, e.o}) begin
          errors++;
          $display("FAIL result: got S=%h cout=%b ovf=%b, required S=%h cout=%b ovf=%b",
                   S, cout, ovf, e.s, e.c, e.o);
        end
      end
    end
  end

  // Drive one operation; returns cycles from start edge to done and busy count.
  task automatic run_op(input logic [NW-1:0] a, input logic [NW-1:0] b,
                        input logic s, input logic c,
                        output int lat, output int nbusy);
    sb.push_back(model(a, b, s, c));
    A = a; B = b; sub = s; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = $urandom; B = $urandom;
    lat = -1; nbusy = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        lat = i;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    checks++; if (S !== '0)      begin errors++; $display("FAIL reset_S: got %h, required 0", S); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b, required 0", cout); end
    checks++; if (ovf !== 1'b0)  begin errors++; $display("FAIL reset_ovf: got %b, required 0", ovf); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat, nb;
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, lat, nb);
    checks++; if (lat !== 5) begin errors++; $display("FAIL add_latency: got %0d, required 5", lat); end
    checks++; if (nb !== 4)  begin errors++; $display("FAIL add_busy_cycles: got %0d, required 4", nb); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({S, cout, ovf} !== {32'h0000_0100, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_hold: got S=%h cout=%b ovf=%b, required S=00000100 cout=0 ovf=0", S, cout, ovf);
    end
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, lat, nb);
    checks++; if (lat !== 5) begin errors++; $display("FAIL ripple_latency: got %0d, required 5", lat); end
    for (int i = 0; i < 3; i++) begin
      run_op($urandom, $urandom, 1'b0, 1'(i & 1), lat, nb);
      checks++; if (lat !== 5) begin errors++; $display("FAIL rand_add_latency: got %0d, required 5", lat); end
    end
  endtask

  task automatic test_sub();
    int lat, nb;
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, lat, nb);
    run_op(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, lat, nb);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, lat, nb);
    run_op($urandom, $urandom, 1'b1, 1'b0, lat, nb);
    checks++; if (nb !== 4) begin errors++; $display("FAIL sub_busy_cycles: got %0d, required 4", nb); end
  endtask

  task automatic test_ovf();
    int lat, nb;
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, nb);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, lat, nb);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, lat, nb);
  endtask

  task automatic test_protocol();
    int base, dcyc, nd;
    base = n_done; dcyc = -1; nd = 0;
    sb.push_back(model(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1));
    A = 32'h1234_5678; B = 32'h0FED_CBA9; sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (done) begin nd++; dcyc = cyc; end
      if (cyc == 2) begin start = 1'b1; A = $urandom; B = $urandom; sub = 1'b1; cin = 1'b0; end
      if (cyc == 3) start = 1'b0;
    end
    @(posedge clk); #1;
    checks++; if (nd !== 1)   begin errors++; $display("FAIL restart_done_count: got %0d, required 1", nd); end
    checks++; if (dcyc !== 5) begin errors++; $display("FAIL restart_latency: got %0d, required 5", dcyc); end
    checks++; if (n_done - base !== 1) begin errors++; $display("FAIL restart_monitor_count: got %0d, required 1", n_done - base); end
  endtask

  task automatic test_back_to_back();
    int t[3];
    int n, base;
    n = 0; base = n_done;
    for (int i = 0; i < 3; i++) sb.push_back(model(32'hDEAD_BEEF, 32'h3333_4444, 1'b0, 1'b0));
    A = 32'hDEAD_BEEF; B = 32'h3333_4444; sub = 1'b0; cin = 1'b0; start = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (done) begin
        t[n] = cyc;
        n++;
        if (n == 3) begin start = 1'b0; break; end
      end
    end
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_done_count: got %0d, required 3", n); end
    if (n == 3) begin
      checks++; if (t[1] - t[0] !== 6) begin errors++; $display("FAIL b2b_interval0: got %0d, required 6", t[1] - t[0]); end
      checks++; if (t[2] - t[1] !== 6) begin errors++; $display("FAIL b2b_interval1: got %0d, required 6", t[2] - t[1]); end
    end
    checks++; if (n_done - base !== 3) begin errors++; $display("FAIL b2b_total_dones: got %0d, required 3", n_done - base); end
  endtask

  task automatic test_reset_mid();
    int lat, nb, base;
    run_op(32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 1'b0, lat, nb);
    base = n_done;
    A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b, required 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    checks++; if (S !== '0)      begin errors++; $display("FAIL midrst_S: got %h, required 0", S); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL midrst_cout: got %b, required 0", cout); end
    repeat (8) @(posedge clk);
    #1;
    checks++; if (n_done !== base) begin errors++; $display("FAIL midrst_no_done: got %0d dones, required 0", n_done - base); end
    run_op(32'h0102_0304, 32'h0A0B_0C0D, 1'b0, 1'b0, lat, nb);
    checks++; if (lat !== 5) begin errors++; $display("FAIL midrst_recover_latency: got %0d, required 5", lat); end
  endtask

  initial begin
    errors = 0; checks = 0; n_done = 0;
    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; A = '0; B = '0;
    test_reset();
    test_add();
    test_sub();
    test_ovf();
    test_protocol();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d results outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/multiword_add_seq.md
Name: multiword_add_seq

Overview:
Multi-precision add/subtract sequencer. It computes an N*W-bit sum or difference by time-multiplexing one W-bit ripple adder over N cycles, least-significant word first, carrying between words through a carry register. It sits between a requester (start/done handshake) and the team's W-bit adder datapath. The adder stays a single shared instance, so wide arithmetic costs no extra adder area.

Parameters:
W, 32, width of the shared adder word in bits
N, 4, number of words per operand; legal range N >= 2
CW, $clog2(N), word-index counter width (derived, not overridden)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
sub  input  1  0 = A+B+cin, 1 = A-B (B inverted, cin forced to 1)
cin  input  1  carry into word 0 when sub=0; ignored when sub=1
A  input  N*W  operand A, captured on accepted start
B  input  N*W  operand B, captured on accepted start
busy  output  1  high while words are being processed
done  output  1  one-cycle pulse; S, cout and ovf are valid
S  output  N*W  result register
cout  output  1  carry out of the top word (for sub: 1 = no borrow)
ovf  output  1  signed two's-complement overflow of the N*W-bit result

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE; busy=0, done=0, S=0, cout=0, ovf=0; index and carry registers cleared. Reset overrides everything, including mid-RUN. An operation in progress is discarded with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. start=1 at an edge:
  - capture A into a_sh and (sub ? ~B : B) into b_sh;
  - carry <= sub ? 1 : cin; idx <= 0;
  - state -> RUN.
  - A and B may change freely after the capture edge.
- RUN (busy=1): each cycle the adder computes {c,s} = a_sh[W-1:0] + b_sh[W-1:0] + carry.
  - Edge: S is shifted right by W with s inserted at S[N*W-1:(N-1)*W].
  - a_sh and b_sh shift right by W; carry <= c; idx <= idx+1.
  - When idx==N-1, additionally:
    - cout <= c;
    - ovf <= (a_msb == b_eff_msb) && (s_msb != a_msb), using the MSBs of the word being added;
    - state -> DONE.
- DONE: done=1, busy=0 for exactly one cycle, then state -> IDLE. start is ignored in DONE.
- Latency: start accepted at edge k → busy high cycles k+1..k+N → done high in cycle k+N+1. With start held high, the throughput is one operation per N+2 cycles.
- S, cout and ovf hold their values from done until the next accepted start. While busy, S contains partial shifted data and is not valid.
- start during RUN is ignored and has no effect on the operation in progress.
- Width rules: all arithmetic is modulo 2^(N*W). carry out of word i feeds only word i+1. No carry escapes except through cout.
- Subtraction: cout=1 means A >= B unsigned; cout=0 means a borrow occurred.

Test Plan:
- Single-word carry (W=8, N=4): A=0x000000FF, B=0x00000001, sub=0, cin=0 → S=0x00000100, cout=0, ovf=0. busy lasts 4 cycles and done pulses exactly 5 cycles after the start edge.
- Full carry ripple: A=0xFFFFFFFF, B=0, cin=1 → S=0x00000000, cout=1, ovf=0.
- Subtract with borrow: A=0x00000005, B=0x00000007, sub=1, cin=0 → S=0xFFFFFFFE, cout=0, ovf=0. Also: A=7, B=5 → S=0x00000002, cout=1.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001, add → S=0x80000000, ovf=1, cout=0. Also: A=0x80000000 - B=0x00000001 → S=0x7FFFFFFF, ovf=1.
- Protocol: pulse start again at busy cycle 2, and change A/B mid-RUN → result equals the first operands and only one done pulse occurs. Hold start high continuously → done pulses every 6 cycles.
- Reset mid-operation: assert rst at busy cycle 2 → next cycle busy=0, S=0, cout=0, no done pulse. A new start afterwards completes normally.
